// File: rtl/dmem_host_pkg.sv
// Shared definitions for the data-memory host port: mode encodings, FSM states
// and the default character-buffer location used by the firmware memory map.
package dmem_host_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_EXEC = 2'b10;
  localparam logic [1:0] MODE_READ = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_EXEC_RST = 3'd2,
    S_RUN      = 3'd3,
    S_READ     = 3'd4
  } state_t;

  localparam int DEF_BUF_BASE = 1500;
  localparam int DEF_BUF_LEN  = 108;

endpackage

// File: rtl/dmem_host_port_load_counter.sv
// Character counter for one load session: accepted count, full flag and a
// sticky overflow flag raised when a character is offered while full.
module load_counter #(
  parameter int BUF_LEN = 108,
  parameter int CNT_W   = $clog2(BUF_LEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic             offer,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(BUF_LEN);

  assign full = (count == LEN_C);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (inc && !full) begin
        count <= count + 1'b1;
      end
      if (offer && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_host_port.sv
// Data-memory front end: arbitrates the single-port RAM between the host
// character loader, the processor and host readback under a mode FSM.
//
// Handshake: a character transfers on a rising edge where host_valid and
// host_ready are both high; host_valid may be held without a transfer, and
// host_ready depends only on state and fill level, never on host_valid.
module dmem_host_port
  import dmem_host_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int CHAR_W   = 8,
  parameter int BUF_BASE = DEF_BUF_BASE,
  parameter int BUF_LEN  = DEF_BUF_LEN,
  parameter int CNT_W    = $clog2(BUF_LEN + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              host_valid,
  input  logic [CHAR_W-1:0] host_data,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_raddr,
  output logic              rd_valid,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_reset,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [CNT_W-1:0]  load_count,
  output logic              load_full,
  output logic              load_overflow,
  output logic [2:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BUF_BASE);

  state_t state, next_state;
  logic   xfer;
  logic   enter_load;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = S_IDLE;
    case (mode)
      MODE_IDLE: next_state = S_IDLE;
      MODE_LOAD: next_state = S_LOAD;
      MODE_READ: next_state = S_READ;
      MODE_EXEC: next_state = (state == S_EXEC_RST || state == S_RUN) ? S_RUN : S_EXEC_RST;
      default:   next_state = S_IDLE;
    endcase
  end

  assign host_ready = (state == S_LOAD) && !load_full;
  assign xfer       = host_valid && host_ready;
  // Clearing on the entry edge is safe: no transfer can happen outside S_LOAD.
  assign enter_load = (state != S_LOAD) && (next_state == S_LOAD);
  assign cpu_reset  = (state != S_RUN);
  assign dbg_state  = state;

  load_counter #(
    .BUF_LEN (BUF_LEN),
    .CNT_W   (CNT_W)
  ) u_load_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (enter_load),
    .inc      (xfer),
    .offer    (host_valid && (state == S_LOAD)),
    .count    (load_count),
    .full     (load_full),
    .overflow (load_overflow)
  );

  always_comb begin
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_LOAD: begin
        mem_wen   = xfer;
        mem_addr  = BASE_A + ADDR_W'(load_count);
        mem_wdata = DATA_W'(host_data);
      end
      S_RUN: begin
        mem_wen   = cpu_wren;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      S_READ: begin
        mem_addr  = host_raddr;
      end
      default: begin
        mem_wen   = 1'b0;
      end
    endcase
  end

  // Aligns with the one-cycle synchronous RAM read issued during S_READ.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= (state == S_READ);
    end
  end

endmodule

// File: tb/tb_dmem_host_port.sv
// Directed self-checking bench for dmem_host_port with a behavioural
// single-port synchronous RAM attached to the memory side.
module tb_dmem_host_port;
  import dmem_host_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int CHAR_W = 8;
  localparam int CNT_W  = 7;

  logic              clock = 1'b0;
  logic              reset;
  logic [1:0]        mode;
  logic              host_valid;
  logic [CHAR_W-1:0] host_data;
  logic              host_ready;
  logic [ADDR_W-1:0] host_raddr;
  logic              rd_valid;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_reset;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [CNT_W-1:0]  load_count;
  logic              load_full;
  logic              load_overflow;
  logic [2:0]        dbg_state;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram_rdata;

  int errors = 0;
  int checks = 0;
  int wr_seen;

  dmem_host_port dut (
    .clock         (clock),
    .reset         (reset),
    .mode          (mode),
    .host_valid    (host_valid),
    .host_data     (host_data),
    .host_ready    (host_ready),
    .host_raddr    (host_raddr),
    .rd_valid      (rd_valid),
    .cpu_wren      (cpu_wren),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_reset     (cpu_reset),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .load_count    (load_count),
    .load_full     (load_full),
    .load_overflow (load_overflow),
    .dbg_state     (dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wen) ram[mem_addr] <= mem_wdata;
    ram_rdata <= ram[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_state"},     64'(dbg_state),  64'(S_IDLE));
    check_eq({tag, "_cpu_reset"}, 64'(cpu_reset),  64'd1);
    check_eq({tag, "_ready"},     64'(host_ready), 64'd0);
    check_eq({tag, "_wen"},       64'(mem_wen),    64'd0);
    check_eq({tag, "_addr"},      64'(mem_addr),   64'd0);
    check_eq({tag, "_wdata"},     64'(mem_wdata),  64'd0);
  endtask

  // driver: offer one character in the current cycle and advance one edge
  task automatic offer_char(input logic [7:0] ch, input bit exp_write, input int exp_addr, input string tag);
    host_valid = 1'b1;
    host_data  = ch;
    #1;
    check_eq({tag, "_wen"}, 64'(mem_wen), 64'(exp_write));
    if (exp_write) begin
      check_eq({tag, "_addr"},  64'(mem_addr),  64'(exp_addr));
      check_eq({tag, "_wdata"}, 64'(mem_wdata), 64'(ch));
    end
    if (mem_wen) wr_seen++;
    tick();
    host_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'hDEAD_BEEF;
    reset = 1'b1; mode = MODE_IDLE; host_valid = 1'b0; host_data = '0;
    host_raddr = '0; cpu_wren = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(); tick();

    // reset state
    check_idle_outputs("rst");
    check_eq("rst_count",    64'(load_count),    64'd0);
    check_eq("rst_full",     64'(load_full),     64'd0);
    check_eq("rst_ovf",      64'(load_overflow), 64'd0);
    check_eq("rst_rd_valid", 64'(rd_valid),      64'd0);
    reset = 1'b0;

    // fill past capacity: 110 offers, 108 accepted
    mode = MODE_LOAD;
    tick();
    check_eq("ld_state", 64'(dbg_state),  64'(S_LOAD));
    check_eq("ld_ready", 64'(host_ready), 64'd1);
    wr_seen = 0;
    for (int i = 0; i < 110; i++) begin
      if (i == 108) begin
        check_eq("full_ready", 64'(host_ready), 64'd0);
        check_eq("full_flag",  64'(load_full),  64'd1);
        check_eq("pre_ovf",    64'(load_overflow), 64'd0);
      end
      offer_char(8'(i + 1), (i < 108), 1500 + i, "fill");
    end
    check_eq("fill_writes", 64'(wr_seen),       64'd108);
    check_eq("fill_count",  64'(load_count),    64'd108);
    check_eq("fill_ovf",    64'(load_overflow), 64'd1);
    check_eq("ram_1500",    64'(ram[1500]),     64'h1);
    check_eq("ram_1607",    64'(ram[1607]),     64'd108);
    check_eq("ram_1608",    64'(ram[1608]),     64'hDEAD_BEEF);

    // leaving LOAD retains; re-entering clears
    mode = MODE_IDLE;
    tick();
    check_eq("idle_count", 64'(load_count),    64'd108);
    check_eq("idle_ovf",   64'(load_overflow), 64'd1);
    mode = MODE_LOAD;
    tick();
    check_eq("reld_count", 64'(load_count),    64'd0);
    check_eq("reld_ovf",   64'(load_overflow), 64'd0);
    offer_char(8'h41, 1'b1, 1500, "c0");
    offer_char(8'h42, 1'b1, 1501, "c1");
    offer_char(8'h43, 1'b1, 1502, "c2");
    check_eq("abc_count", 64'(load_count), 64'd3);
    check_eq("abc_ready", 64'(host_ready), 64'd1);
    check_eq("ram_1502",  64'(ram[1502]),  64'h43);

    // readback of 1502
    mode = MODE_READ; host_raddr = 12'd1502;
    tick();
    check_eq("rd_state", 64'(dbg_state), 64'(S_READ));
    check_eq("rd_addr",  64'(mem_addr),  64'd1502);
    check_eq("rd_wen",   64'(mem_wen),   64'd0);
    check_eq("rd_v0",    64'(rd_valid),  64'd0);
    tick();
    check_eq("rd_v1",    64'(rd_valid),  64'd1);
    check_eq("rd_data",  64'(ram_rdata), 64'h43);
    check_eq("rd_count", 64'(load_count), 64'd3);

    // exec entry: two edges of processor reset, write dropped in S_EXEC_RST
    mode = MODE_IDLE;
    tick();
    cpu_wren = 1'b1; cpu_addr = 12'h010; cpu_wdata = 32'h1234_5678;
    mode = MODE_EXEC;
    #1;
    check_eq("ex_rst0", 64'(cpu_reset), 64'd1);
    tick();
    check_eq("ex_state1", 64'(dbg_state), 64'(S_EXEC_RST));
    check_eq("ex_rst1",   64'(cpu_reset), 64'd1);
    check_eq("ex_wen1",   64'(mem_wen),   64'd0);
    check_eq("ex_addr1",  64'(mem_addr),  64'd0);
    tick();
    check_eq("ex_state2", 64'(dbg_state), 64'(S_RUN));
    check_eq("ex_rst2",   64'(cpu_reset), 64'd0);
    check_eq("ex_wen2",   64'(mem_wen),   64'd1);
    check_eq("ex_addr2",  64'(mem_addr),  64'h010);
    check_eq("ex_wdata2", 64'(mem_wdata), 64'h1234_5678);
    tick();
    check_eq("ex_rst3",   64'(cpu_reset), 64'd0);
    check_eq("ram_010",   64'(ram[16]),   64'h1234_5678);
    cpu_wren = 1'b0;

    // reset in the middle of a session at count 40
    mode = MODE_LOAD;
    tick();
    for (int i = 0; i < 40; i++) offer_char(8'(8'h80 + i), 1'b1, 1500 + i, "mid");
    check_eq("mid_count", 64'(load_count), 64'd40);
    host_valid = 1'b1; host_data = 8'h55; reset = 1'b1;
    #1;
    check_eq("mid_inflight_wen",  64'(mem_wen),  64'd1);
    check_eq("mid_inflight_addr", 64'(mem_addr), 64'd1540);
    tick();
    host_valid = 1'b0;
    #1;
    check_idle_outputs("mrst");
    check_eq("mrst_count", 64'(load_count),    64'd0);
    check_eq("mrst_ovf",   64'(load_overflow), 64'd0);
    check_eq("mrst_full",  64'(load_full),     64'd0);
    check_eq("ram_1540",   64'(ram[1540]),     64'h55);
    reset = 1'b0; mode = MODE_IDLE;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
